// File: rtl/daio_rx_sequencer_pkg.sv
// Shared definitions for the digital-audio receive sequencer: state codes,
// control/status bit positions and default frame geometry.
package daio_rx_sequencer_pkg;

  typedef enum logic [3:0] {
    L0_IDLE        = 4'd0,
    L1_HUNT        = 4'd1,
    L2_A_START_BLK = 4'd2,
    L3_A_DATA_BLK  = 4'd3,
    L4_WAIT_B      = 4'd4,
    L5_B_DATA      = 4'd5,
    L6_WAIT_A      = 4'd6,
    L7_A_DATA      = 4'd7,
    L8_WAIT_BLK    = 4'd8,
    L9_ERROR       = 4'd9,
    L10_RECOVER    = 4'd10
  } state_t;

  localparam int RXC_ENABLE   = 0;
  localparam int RXC_CLR_ERR  = 1;
  localparam int RXC_XSEL_LSB = 2;
  localparam int RXC_XSEL_MSB = 3;

  localparam int RXS_SYNC_ERR = 0;
  localparam int RXS_LOCKED   = 1;

  localparam int DEFAULT_SUBFRAME_BITS    = 28;
  localparam int DEFAULT_FRAMES_PER_BLOCK = 192;
  localparam int DEFAULT_PREAMBLE_TIMEOUT = 64;

  function automatic logic is_wait(state_t s);
    return (s == L4_WAIT_B) || (s == L6_WAIT_A) || (s == L8_WAIT_BLK);
  endfunction

  function automatic logic is_locked(state_t s);
    return (s >= L2_A_START_BLK) && (s <= L8_WAIT_BLK);
  endfunction

endpackage

// File: rtl/daio_rx_sequencer_if.sv
// Bus between the biphase decoder / register bank side (master) and the
// receive sequencer (slave).
interface daio_rx_sequencer_if;
  logic [3:0] xtal;
  logic [3:0] rx_control;
  logic       preamble_1;
  logic       preamble_2;
  logic       preamble_3;
  logic       carrier_loss;
  logic [3:0] pc;
  logic       load_A;
  logic       load_B;
  logic       load_buff;
  logic [8:0] frame_counter;
  logic       clock_out;
  logic [1:0] rx_status_hi;

  modport master (
    output xtal, rx_control, preamble_1, preamble_2, preamble_3, carrier_loss,
    input  pc, load_A, load_B, load_buff, frame_counter, clock_out, rx_status_hi
  );

  modport slave (
    input  xtal, rx_control, preamble_1, preamble_2, preamble_3, carrier_loss,
    output pc, load_A, load_B, load_buff, frame_counter, clock_out, rx_status_hi
  );
endinterface

// File: rtl/daio_preamble_timer.sv
// Loadable 7-bit cycle counter that flags when a waiting state has lasted
// TIMEOUT cycles without its preamble.
module daio_preamble_timer
  import daio_rx_sequencer_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_PREAMBLE_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam logic [6:0] LAST = 7'(TIMEOUT - 1);

  logic [6:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its peers, independent of process ordering.
  always_ff @(posedge clock) begin
    if (reset || load) count <= '0;
    else if (enable)   count <= count + 7'd1;
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/daio_rx_sequencer.sv
// Frame/subframe sequencer: follows preambles, paces subframe data bits,
// strobes the register bank and keeps the block frame index.
module daio_rx_sequencer
  import daio_rx_sequencer_pkg::*;
#(
  parameter int SUBFRAME_BITS    = DEFAULT_SUBFRAME_BITS,
  parameter int FRAMES_PER_BLOCK = DEFAULT_FRAMES_PER_BLOCK,
  parameter int PREAMBLE_TIMEOUT = DEFAULT_PREAMBLE_TIMEOUT
) (
  input logic             clock,
  input logic             reset,
  daio_rx_sequencer_if.slave bus
);

  localparam logic [6:0] BIT_LAST   = 7'(SUBFRAME_BITS - 1);
  localparam logic [8:0] FRAME_LAST = 9'(FRAMES_PER_BLOCK - 1);

  state_t     state, next_state;
  logic [6:0] bit_count_a, bit_count_a_nxt;
  logic [6:0] bit_count_b, bit_count_b_nxt;
  logic [8:0] frame_count, frame_count_nxt;
  logic       load_a, load_b, load_buff;
  logic       load_a_nxt, load_b_nxt, load_buff_nxt;
  logic       locked, sync_err;
  logic       enable, p_exp, p_unexp, expired, stay_wait, set_err, clear_all;

  assign enable    = bus.rx_control[RXC_ENABLE];
  assign stay_wait = is_wait(state) && (next_state == state);

  daio_preamble_timer #(.TIMEOUT(PREAMBLE_TIMEOUT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (!stay_wait),
    .enable  (stay_wait),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= L0_IDLE;
      bit_count_a   <= '0;
      bit_count_b   <= '0;
      frame_count   <= '0;
      load_a        <= 1'b0;
      load_b        <= 1'b0;
      load_buff     <= 1'b0;
      locked        <= 1'b0;
      sync_err      <= 1'b0;
      bus.clock_out <= 1'b0;
    end else begin
      state         <= next_state;
      bit_count_a   <= bit_count_a_nxt;
      bit_count_b   <= bit_count_b_nxt;
      frame_count   <= frame_count_nxt;
      load_a        <= load_a_nxt;
      load_b        <= load_b_nxt;
      load_buff     <= load_buff_nxt;
      locked        <= is_locked(next_state);
      // A new error in the same cycle as a clear request survives.
      sync_err      <= set_err | (sync_err & ~bus.rx_control[RXC_CLR_ERR]);
      bus.clock_out <= bus.xtal[bus.rx_control[RXC_XSEL_MSB:RXC_XSEL_LSB]];
    end
  end

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    p_exp      = 1'b0;
    p_unexp    = 1'b0;
    case (state)
      L4_WAIT_B:   begin p_exp = bus.preamble_3; p_unexp = bus.preamble_1 | bus.preamble_2; end
      L6_WAIT_A:   begin p_exp = bus.preamble_2; p_unexp = bus.preamble_1 | bus.preamble_3; end
      L8_WAIT_BLK: begin p_exp = bus.preamble_1; p_unexp = bus.preamble_2 | bus.preamble_3; end
      default: ;
    endcase

    if (!enable)
      next_state = L0_IDLE;
    else if (bus.carrier_loss && state != L0_IDLE)
      next_state = L9_ERROR;
    else if (is_wait(state) && (p_unexp || (expired && !p_exp)))
      next_state = L1_HUNT;
    else begin
      case (state)
        L0_IDLE:        next_state = L1_HUNT;
        L1_HUNT:        if (bus.preamble_1) next_state = L2_A_START_BLK;
        L2_A_START_BLK: next_state = L3_A_DATA_BLK;
        L3_A_DATA_BLK,
        L7_A_DATA:      if (bit_count_a == BIT_LAST) next_state = L4_WAIT_B;
        L5_B_DATA:      if (bit_count_b == BIT_LAST)
                          next_state = (frame_count == FRAME_LAST) ? L8_WAIT_BLK : L6_WAIT_A;
        L4_WAIT_B:      if (p_exp) next_state = L5_B_DATA;
        L6_WAIT_A:      if (p_exp) next_state = L7_A_DATA;
        L8_WAIT_BLK:    if (p_exp) next_state = L2_A_START_BLK;
        L9_ERROR:       next_state = L10_RECOVER;
        L10_RECOVER:    next_state = L1_HUNT;
        default:        next_state = L0_IDLE;
      endcase
    end
  end

  // Strobes and counter updates follow from the transition actually taken,
  // so a pre-empted transition can never emit a strobe.
  always_comb begin
    load_a_nxt    = (state == L3_A_DATA_BLK || state == L7_A_DATA) && next_state == L4_WAIT_B;
    load_b_nxt    = (state == L5_B_DATA) && (next_state == L6_WAIT_A || next_state == L8_WAIT_BLK);
    load_buff_nxt = (state == L5_B_DATA) && (next_state == L8_WAIT_BLK);
    set_err       = is_wait(state) && (next_state == L1_HUNT);
    clear_all     = (next_state == L0_IDLE) || set_err ||
                    (state == L10_RECOVER && next_state == L1_HUNT);

    bit_count_a_nxt = bit_count_a;
    if (clear_all || load_a_nxt)
      bit_count_a_nxt = '0;
    else if ((state == L3_A_DATA_BLK || state == L7_A_DATA) && next_state == state)
      bit_count_a_nxt = bit_count_a + 7'd1;

    bit_count_b_nxt = bit_count_b;
    if (clear_all || load_b_nxt)
      bit_count_b_nxt = '0;
    else if (state == L5_B_DATA && next_state == state)
      bit_count_b_nxt = bit_count_b + 7'd1;

    frame_count_nxt = frame_count;
    if (clear_all)
      frame_count_nxt = '0;
    else if (load_b_nxt)
      frame_count_nxt = (frame_count == FRAME_LAST) ? 9'd0 : frame_count + 9'd1;
  end

  assign bus.pc                         = state;
  assign bus.load_A                     = load_a;
  assign bus.load_B                     = load_b;
  assign bus.load_buff                  = load_buff;
  assign bus.frame_counter              = frame_count;
  assign bus.rx_status_hi[RXS_LOCKED]   = locked;
  assign bus.rx_status_hi[RXS_SYNC_ERR] = sync_err;

endmodule

// File: tb/tb_daio_rx_sequencer.sv
// Self-checking bench for daio_rx_sequencer: a frame-level reference model is
// compared with the DUT every cycle, plus directed scenarios with literal values.
module tb_daio_rx_sequencer;
  import daio_rx_sequencer_pkg::*;

  localparam int SB  = DEFAULT_SUBFRAME_BITS;
  localparam int FPB = DEFAULT_FRAMES_PER_BLOCK;
  localparam int TO  = DEFAULT_PREAMBLE_TIMEOUT;

  logic clock = 1'b0;
  logic reset = 1'b1;

  daio_rx_sequencer_if bus ();

  daio_rx_sequencer #(
    .SUBFRAME_BITS    (SB),
    .FRAMES_PER_BLOCK (FPB),
    .PREAMBLE_TIMEOUT (TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase code is the pc value; a data phase counts remaining bits down, a
  // waiting phase counts how long it has waited.
  typedef struct {
    int pc;
    int left;
    int waited;
    int frame;
    bit err;
    bit la;
    bit lb;
    bit lbuf;
    bit clk;
  } model_t;

  model_t m;
  bit     model_on = 1'b0;

  function automatic int expected_pre(input int pc);
    case (pc)
      1, 8:    return 1;
      6:       return 2;
      4:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic model_t model_next(input model_t s, input logic rst, input logic [3:0] ctrl,
                                        input logic [3:0] xt, input logic p1, input logic p2,
                                        input logic p3, input logic cl);
    model_t n = s;
    int     want;
    bit     got, unexp, set_err;
    n.la = 1'b0; n.lb = 1'b0; n.lbuf = 1'b0; set_err = 1'b0;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    n.clk = xt[ctrl[3:2]];
    want  = expected_pre(s.pc);
    got   = (want == 1 && p1) || (want == 2 && p2) || (want == 3 && p3);
    unexp = (p1 && want != 1) || (p2 && want != 2) || (p3 && want != 3);
    if (!ctrl[0]) begin
      n.pc = 0; n.frame = 0;
    end else if (cl && s.pc != 0) begin
      n.pc = 9;
    end else begin
      case (s.pc)
        0: n.pc = 1;
        1: if (p1) n.pc = 2;
        2: begin n.pc = 3; n.left = SB; end
        3, 7: begin
          n.left = s.left - 1;
          if (n.left == 0) begin n.pc = 4; n.la = 1'b1; n.waited = 0; end
        end
        5: begin
          n.left = s.left - 1;
          if (n.left == 0) begin
            n.lb = 1'b1;
            n.waited = 0;
            if (s.frame == FPB - 1) begin n.pc = 8; n.lbuf = 1'b1; end
            else n.pc = 6;
            n.frame = (s.frame + 1) % FPB;
          end
        end
        4, 6, 8: begin
          if (unexp || (!got && s.waited + 1 >= TO)) begin
            n.pc = 1; n.frame = 0; set_err = 1'b1;
          end else if (got) begin
            n.pc   = (s.pc == 4) ? 5 : (s.pc == 6) ? 7 : 2;
            n.left = SB;
          end else begin
            n.waited = s.waited + 1;
          end
        end
        9:  n.pc = 10;
        10: begin n.pc = 1; n.frame = 0; end
        default: n.pc = 0;
      endcase
    end
    n.err = set_err || (s.err && !ctrl[1]);
    return n;
  endfunction

  always @(posedge clock) begin
    m <= model_next(m, reset, bus.rx_control, bus.xtal, bus.preamble_1, bus.preamble_2,
                    bus.preamble_3, bus.carrier_loss);
    model_on <= 1'b1;
  end

  // ---------------- per-cycle compare + pulse monitor ----------------
  int n_la = 0, n_lb = 0, n_buff = 0, n_buff_alone = 0;

  always @(negedge clock) begin
    if (model_on) begin
      check("pc", bus.pc, m.pc);
      check("load_A", bus.load_A, m.la);
      check("load_B", bus.load_B, m.lb);
      check("load_buff", bus.load_buff, m.lbuf);
      check("frame_counter", bus.frame_counter, m.frame);
      check("clock_out", bus.clock_out, m.clk);
      check("rx_status_hi", bus.rx_status_hi, {(m.pc >= 2 && m.pc <= 8), m.err});
      if (bus.load_A) n_la++;
      if (bus.load_B) n_lb++;
      if (bus.load_buff) n_buff++;
      if (bus.load_buff && !bus.load_B) n_buff_alone++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      bus.xtal = 4'($urandom);
    end
  endtask

  task automatic set_pre(input int w);
    bus.preamble_1 = (w == 1);
    bus.preamble_2 = (w == 2);
    bus.preamble_3 = (w == 3);
  endtask

  // Drive well-formed preambles until the model reaches the requested phase.
  task automatic run_until(input int tgt_pc, input int tgt_frame, input int budget);
    int n = 0;
    bit reached;
    reached = (m.pc == tgt_pc) && (tgt_frame < 0 || m.frame == tgt_frame);
    while (!reached && n < budget) begin
      set_pre(0);
      if (expected_pre(m.pc) != 0 && $urandom_range(0, 1) == 0) set_pre(expected_pre(m.pc));
      step(1);
      n++;
      reached = (m.pc == tgt_pc) && (tgt_frame < 0 || m.frame == tgt_frame);
    end
    set_pre(0);
    if (!reached) check("run_until_reached", 32'(reached), 32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int silent;
    bit b;
    bus.xtal = '0; bus.rx_control = '0; bus.carrier_loss = 1'b0; set_pre(0);
    reset = 1'b1;
    step(3);
    check("reset_pc", bus.pc, 0);
    check("reset_status", bus.rx_status_hi, 0);
    check("reset_frame", bus.frame_counter, 0);
    check("reset_clock_out", bus.clock_out, 0);
    check("reset_load_A", bus.load_A, 0);
    n_la = 0; n_lb = 0; n_buff = 0; n_buff_alone = 0;

    // Reset and enable, first subframe A timing
    reset = 1'b0; bus.rx_control = 4'b0001;
    step(1);  check("enable_pc_L1", bus.pc, 1);
    step(3);  set_pre(1);
    step(1);  set_pre(0);
    check("p1_pc_L2", bus.pc, 2);
    check("L2_locked", bus.rx_status_hi, 2'b10);
    step(1);  check("pc_L3", bus.pc, 3);
    step(27); check("L3_last_bit_pc", bus.pc, 3);
    check("L3_last_bit_no_load", bus.load_A, 0);
    step(1);  check("load_A_pc_L4", bus.pc, 4);
    check("load_A_pulse", bus.load_A, 1);
    step(1);  check("load_A_single", bus.load_A, 0);

    // Full block
    run_until(8, -1, 20000);
    step(1);
    check("block_load_A_count", n_la, 192);
    check("block_load_B_count", n_lb, 192);
    check("block_load_buff_count", n_buff, 1);
    check("block_buff_without_B", n_buff_alone, 0);
    check("block_frame_wrap", bus.frame_counter, 0);
    check("block_pc_L8", bus.pc, 8);

    // Preamble mismatch in L4
    run_until(4, 2, 2000);
    set_pre(2);
    step(1); set_pre(0);
    check("mismatch_pc_L1", bus.pc, 1);
    check("mismatch_status", bus.rx_status_hi, 2'b01);
    check("mismatch_frame_clr", bus.frame_counter, 0);
    bus.rx_control = 4'b0011;
    step(1); bus.rx_control = 4'b0001;
    check("err_cleared", bus.rx_status_hi, 2'b00);

    // Preamble timeout in L6
    run_until(6, -1, 2000);
    step(63); check("timeout_still_L6", bus.pc, 6);
    step(1);  check("timeout_pc_L1", bus.pc, 1);
    check("timeout_status", bus.rx_status_hi, 2'b01);
    bus.rx_control = 4'b0011;
    step(1); bus.rx_control = 4'b0001;
    run_until(6, -1, 2000);
    step(63); set_pre(2);
    step(1);  set_pre(0);
    check("late_preamble_pc_L7", bus.pc, 7);
    check("late_preamble_status", bus.rx_status_hi, 2'b10);

    // Carrier loss on the final bit of subframe B
    run_until(5, 3, 2000);
    step(27); bus.carrier_loss = 1'b1;
    step(1);  bus.carrier_loss = 1'b0;
    check("carrier_pc_L9", bus.pc, 9);
    check("carrier_no_load_B", bus.load_B, 0);
    check("carrier_frame_kept", bus.frame_counter, 3);
    step(1);  check("carrier_pc_L10", bus.pc, 10);
    step(1);  check("carrier_pc_L1", bus.pc, 1);

    // Disable mid-L5, then clock select
    run_until(5, -1, 2000);
    step(10); bus.rx_control = 4'b0000;
    step(1);
    check("disable_pc_L0", bus.pc, 0);
    check("disable_no_load_B", bus.load_B, 0);
    check("disable_frame_clr", bus.frame_counter, 0);
    bus.rx_control = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      b = bus.xtal[2];
      step(1);
      check("clock_out_xtal2", bus.clock_out, b);
    end

    // Randomized traffic with faults, checked by the model
    bus.rx_control = 4'b0001;
    silent = 0;
    for (int i = 0; i < 4000; i++) begin
      set_pre(0);
      if (silent > 0) silent--;
      else if ($urandom_range(0, 399) == 0) silent = 70;
      else if (expected_pre(m.pc) != 0 && $urandom_range(0, 2) == 0) set_pre(expected_pre(m.pc));
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(1, 3))
          1:       bus.preamble_1 = 1'b1;
          2:       bus.preamble_2 = 1'b1;
          default: bus.preamble_3 = 1'b1;
        endcase
      end
      bus.carrier_loss  = ($urandom_range(0, 149) == 0);
      bus.rx_control[3:2] = 2'($urandom_range(0, 3));
      bus.rx_control[1] = ($urandom_range(0, 39) == 0);
      bus.rx_control[0] = ($urandom_range(0, 399) != 0);
      reset = (i == 2000);
      step(1);
    end
    reset = 1'b0; set_pre(0); bus.carrier_loss = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/daio_rx_sequencer.md
# daio_rx_sequencer

Frame/subframe sequencer for the digital-audio receive path. Tracks preamble events from the biphase decoder and steps the 4-bit program counter `pc` (L0..L10) that gates shifting and parity in the receive datapath. Issues `load_A`, `load_B` and `load_buff` strobes to the register bank, and maintains the 192-frame block counter. It also drives lock and sync-error status bits and the receive clock select.

## Interface
- `SUBFRAME_BITS`, 28: data bits per subframe after the preamble slot; legal range 2..127.
- `FRAMES_PER_BLOCK`, 192: frames per block; legal range 2..511.
- `PREAMBLE_TIMEOUT`, 64: maximum cycles spent waiting for an expected preamble; legal range 1..127.
- `clock` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `xtal` in 4: candidate receive clocks.
- `rx_control` in 4: [0] enable; [1] clear sync error; [3:2] xtal select.
- `preamble_1`, `preamble_2`, `preamble_3` in 1 each: block start, subframe A start and subframe B start, respectively.
- `carrier_loss` in 1: carrier lost.
- `pc` out 4: sequencer state.
- `load_A`, `load_B`, `load_buff` out 1 each: single-cycle strobes.
- `frame_counter` out 9: frame index within the current block.
- `clock_out` out 1: registered `xtal[rx_control[3:2]]`.
- `rx_status_hi` out 2: [1] locked; [0] sticky sync error.

## Operation
States:
- **L0 IDLE**
- **L1 HUNT**
- **L2 A_START_BLK**
- **L3 A_DATA_BLK**
- **L4 WAIT_B**
- **L5 B_DATA**
- **L6 WAIT_A**
- **L7 A_DATA**
- **L8 WAIT_BLK**
- **L9 ERROR**
- **L10 RECOVER**

Transitions:
- L0 -> L1 when `rx_control[0]` = 1.
- L1 -> L2 on `preamble_1`. `preamble_2` and `preamble_3` are ignored in L1.
- L2 -> L3 unconditionally.
- L3, L5 and L7 increment their bit counter every cycle (`bit_count_A` in L3/L7, `bit_count_B` in L5). When the count equals `SUBFRAME_BITS`-1:
  - clear the counter;
  - L3/L7 -> L4 with `load_A`;
  - L5 -> L6 with `load_B`, or L5 -> L8 with `load_B` and `load_buff` if `frame_counter` = `FRAMES_PER_BLOCK`-1.
- `load_B` increments `frame_counter`, wrapping to 0 at `FRAMES_PER_BLOCK`-1.
- Waiting states advance on the expected preamble:
  - L4 -> L5 on `preamble_3`;
  - L6 -> L7 on `preamble_2`;
  - L8 -> L2 on `preamble_1`.
- Mismatch or timeout in a waiting state:
  - An unexpected preamble in L4/L6/L8, or `PREAMBLE_TIMEOUT` cycles without the expected one, sends the sequencer to L1.
  - It also sets sync error and clears `frame_counter` and both bit counters.
  - The timeout counter resets on entry to every waiting state.
- Carrier loss: `carrier_loss` in any state except L0 sends the sequencer to L9. The first cycle with `carrier_loss` = 0 in L9 moves it to L10. L10 clears all counters, then goes to L1.

Priority, highest first:
1. `reset`
2. enable = 0 (-> L0, all counters cleared)
3. `carrier_loss`
4. mismatch/timeout
5. normal transition

A suppressed transition emits no strobe. For example, the final data bit coinciding with `carrier_loss` produces no `load_A` or `load_B`.

Status:
- Locked = `pc` in L2..L8.
- Sync error is sticky. It is cleared by `reset` or by `rx_control[1]`. If clear and set occur in the same cycle, set wins.

## Timing
- All outputs are registered.
- Reset values: `pc` = L0; all strobes 0; `frame_counter` 0; `clock_out` 0; `rx_status_hi` 00; internal counters 0.
- Preamble to data:
  - Preamble sampled in cycle n puts `pc` = L2/L5/L7 in cycle n+1.
  - From L2, L3 follows in n+2.
- Data phase length: exactly `SUBFRAME_BITS` cycles in L3, L5 or L7.
- Strobe timing:
  - `load_A`/`load_B` are high exactly in the first cycle of the following waiting state.
  - `load_buff` coincides with the `load_B` that closes the block.
  - `frame_counter` shows its new value in that same cycle.
- `clock_out`: one-cycle latency from `xtal` and `rx_control`.
- Reset or disable mid-subframe: no strobe, counters 0 next cycle.

## Structure
- The shared package holds:
  - state constants L0..L10 (4-bit);
  - the bit index names of `rx_control` and `rx_status_hi`;
  - default values for `SUBFRAME_BITS` and `FRAMES_PER_BLOCK`.
- One natural sub-module: `daio_preamble_timer`, the loadable 7-bit timeout counter with an expiry flag.
- The FSM, bit counters and frame counter stay in the top module.

## Test plan
- **Reset and enable:** reset, enable = 1, `preamble_1` at cycle 5 -> `pc` L1, L2 at cycle 6, L3 at cycle 7; `load_A` pulses at cycle 35 with `pc` = L4.
- **Full block:** run 192 frames with correctly spaced preambles -> 192 `load_A` and 192 `load_B` pulses, one `load_buff` coincident with the last `load_B`, `frame_counter` back to 0, `pc` = L8.
- **Preamble mismatch:** `preamble_2` while in L4 -> `pc` = L1 next cycle, `rx_status_hi` = 01 (sync error set, locked clear), counters 0; `rx_control[1]` pulse -> `rx_status_hi` = 00.
- **Preamble timeout:** in L6, withhold `preamble_2` for 64 cycles -> L1 and sync error set; a preamble at cycle 63 -> L7 with no error.
- **Carrier loss on final bit:** `carrier_loss` on the final data bit of subframe B -> L9, no `load_B`, `frame_counter` unchanged; deassert -> L10 then L1.
- **Disable and clock select:** disable mid-L5 -> L0 next cycle, no strobe; `rx_control[3:2]` = 2 -> `clock_out` follows `xtal[2]` with one-cycle delay.
